// File: rtl/word_stack.sv
// Word-wide LIFO stack for the stack calculator datapath.
// One operation per clock from mode; tos/nos feed the ALU directly from registers.
module word_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             d,
    input  logic [2:0]                   mode,
    output logic [WIDTH-1:0]             tos,
    output logic [WIDTH-1:0]             nos,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         empty,
    output logic                         full,
    output logic                         err
);

    localparam int DW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OP_IDLE  = 3'b000,
        OP_PUSH  = 3'b001,
        OP_POP   = 3'b010,
        OP_SWAP  = 3'b011,
        OP_RESET = 3'b100,
        OP_DUP   = 3'b101,
        OP_OVER  = 3'b110,
        OP_ROT   = 3'b111
    } op_e;

    op_e             op;
    logic [WIDTH-1:0] s      [DEPTH];
    logic [WIDTH-1:0] s_next [DEPTH];
    logic [DW-1:0]    depth_next;
    logic             err_next;
    logic             push_en;
    logic [WIDTH-1:0] push_word;
    logic             has1;
    logic             has2;
    logic             has3;

    assign op    = op_e'(mode);
    assign empty = (depth == '0);
    assign full  = (depth == DW'(DEPTH));
    assign has1  = (depth >= DW'(1));
    assign has2  = (depth >= DW'(2));
    assign has3  = (depth >= DW'(3));
    assign tos   = s[0];
    assign nos   = s[1];

    // PUSH, DUP and OVER share one shift-down path; only the pushed word differs.
    always_comb begin
        s_next     = s;
        depth_next = depth;
        err_next   = err;
        push_en    = 1'b0;
        push_word  = '0;

        case (op)
            OP_PUSH: begin
                if (!full) begin
                    push_en   = 1'b1;
                    push_word = d;
                end else begin
                    err_next = 1'b1;
                end
            end
            OP_POP: begin
                if (has1) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        s_next[i] = s[i+1];
                    end
                    s_next[DEPTH-1] = '0;
                    depth_next      = depth - DW'(1);
                end else begin
                    err_next = 1'b1;
                end
            end
            OP_SWAP: begin
                if (has2) begin
                    s_next[0] = s[1];
                    s_next[1] = s[0];
                end else begin
                    err_next = 1'b1;
                end
            end
            OP_RESET: begin
                for (int i = 0; i < DEPTH; i++) begin
                    s_next[i] = '0;
                end
                depth_next = '0;
                err_next   = 1'b0;
            end
            OP_DUP: begin
                if (has1 && !full) begin
                    push_en   = 1'b1;
                    push_word = s[0];
                end else begin
                    err_next = 1'b1;
                end
            end
            OP_OVER: begin
                if (has2 && !full) begin
                    push_en   = 1'b1;
                    push_word = s[1];
                end else begin
                    err_next = 1'b1;
                end
            end
            OP_ROT: begin
                if (has3) begin
                    s_next[0] = s[2];
                    s_next[1] = s[0];
                    s_next[2] = s[1];
                end else begin
                    err_next = 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (push_en) begin
            for (int i = 1; i < DEPTH; i++) begin
                s_next[i] = s[i-1];
            end
            s_next[0]  = push_word;
            depth_next = depth + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                s[i] <= '0;
            end
            depth <= '0;
            err   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                s[i] <= s_next[i];
            end
            depth <= depth_next;
            err   <= err_next;
        end
    end

endmodule

// File: tb/tb_word_stack.sv
// Directed bench for word_stack (WIDTH=8, DEPTH=8).
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_word_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH + 1);

    localparam logic [2:0] M_IDLE  = 3'b000;
    localparam logic [2:0] M_PUSH  = 3'b001;
    localparam logic [2:0] M_POP   = 3'b010;
    localparam logic [2:0] M_SWAP  = 3'b011;
    localparam logic [2:0] M_RESET = 3'b100;
    localparam logic [2:0] M_DUP   = 3'b101;
    localparam logic [2:0] M_OVER  = 3'b110;
    localparam logic [2:0] M_ROT   = 3'b111;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] d;
    logic [2:0]       mode;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             err;

    int compared;
    int mismatched;

    word_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .mode  (mode),
        .tos   (tos),
        .nos   (nos),
        .depth (depth),
        .empty (empty),
        .full  (full),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one op for exactly one rising edge, then fall back to IDLE.
    task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] data);
        @(negedge clk);
        mode = op;
        d    = data;
        @(posedge clk);
        #1;
        mode = M_IDLE;
        d    = '0;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [WIDTH-1:0] etos,
                               input logic [WIDTH-1:0] enos,
                               input logic [DW-1:0]    edepth,
                               input logic             eempty,
                               input logic             efull,
                               input logic             eerr);
        logic [2*WIDTH+DW+2:0] obs;
        logic [2*WIDTH+DW+2:0] exp;
        obs = {tos, nos, depth, empty, full, err};
        exp = {etos, enos, edepth, eempty, efull, eerr};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed tos=%h nos=%h depth=%0d empty=%b full=%b err=%b, expected tos=%h nos=%h depth=%0d empty=%b full=%b err=%b",
                   tag, tos, nos, depth, empty, full, err,
                   etos, enos, edepth, eempty, efull, eerr);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        mode       = M_IDLE;
        d          = '0;

        #12;
        checkOutput("reset_state", 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(M_PUSH, 8'(i));
        end
        checkOutput("push5", 8'h05, 8'h04, 4'd5, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle, no clock edge in between.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);

        // Release together with a PUSH: the first edge after release executes it.
        @(negedge clk);
        rst_n = 1'b1;
        mode  = M_PUSH;
        d     = 8'h01;
        @(posedge clk);
        #1;
        mode = M_IDLE;
        checkOutput("push_after_release", 8'h01, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0);

        for (int i = 2; i <= 8; i++) begin
            applyStimulus(M_PUSH, 8'(i));
        end
        checkOutput("fill", 8'h08, 8'h07, 4'd8, 1'b0, 1'b1, 1'b0);

        applyStimulus(M_PUSH, 8'hFF);
        checkOutput("overflow", 8'h08, 8'h07, 4'd8, 1'b0, 1'b1, 1'b1);

        // Draining proves the overflowing PUSH dropped nothing from the bottom.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(M_POP, 8'h00);
            checkOutput($sformatf("drain%0d", k),
                        8'(8 - k),
                        (k <= 6) ? 8'(7 - k) : 8'h00,
                        4'(8 - k), (k == 8), 1'b0, 1'b1);
        end

        applyStimulus(M_RESET, 8'h00);
        checkOutput("reset_op_clear", 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(M_POP, 8'h00);
        checkOutput("underflow", 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(M_RESET, 8'h00);
        checkOutput("reset_op_err", 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);

        applyStimulus(M_PUSH, 8'h11);
        applyStimulus(M_PUSH, 8'h22);
        applyStimulus(M_SWAP, 8'h00);
        checkOutput("swap", 8'h11, 8'h22, 4'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(M_DUP, 8'h00);
        checkOutput("dup", 8'h11, 8'h11, 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(M_OVER, 8'h00);
        checkOutput("over", 8'h11, 8'h11, 4'd4, 1'b0, 1'b0, 1'b0);
        applyStimulus(M_POP, 8'h00);
        applyStimulus(M_POP, 8'h00);
        applyStimulus(M_POP, 8'h00);
        checkOutput("over_bottom", 8'h22, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0);

        applyStimulus(M_RESET, 8'h00);
        applyStimulus(M_PUSH, 8'h0A);
        applyStimulus(M_PUSH, 8'h0B);
        applyStimulus(M_PUSH, 8'h0C);
        applyStimulus(M_ROT, 8'h00);
        checkOutput("rot", 8'h0A, 8'h0C, 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(M_POP, 8'h00);
        checkOutput("rot_pop1", 8'h0C, 8'h0B, 4'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(M_ROT, 8'h00);
        checkOutput("rot_depth2", 8'h0C, 8'h0B, 4'd2, 1'b0, 1'b0, 1'b1);
        applyStimulus(M_POP, 8'h00);
        checkOutput("rot_s2", 8'h0B, 8'h00, 4'd1, 1'b0, 1'b0, 1'b1);

        applyStimulus(M_RESET, 8'h00);
        applyStimulus(M_DUP, 8'h00);
        checkOutput("dup_empty", 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1);

        applyStimulus(M_RESET, 8'h00);
        applyStimulus(M_PUSH, 8'h33);
        applyStimulus(M_OVER, 8'h00);
        checkOutput("over_depth1", 8'h33, 8'h00, 4'd1, 1'b0, 1'b0, 1'b1);

        applyStimulus(M_RESET, 8'h00);
        applyStimulus(M_PUSH, 8'h44);
        applyStimulus(M_SWAP, 8'h00);
        checkOutput("swap_depth1", 8'h44, 8'h00, 4'd1, 1'b0, 1'b0, 1'b1);

        applyStimulus(M_RESET, 8'h00);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(M_PUSH, 8'(8'h10 + i));
        end
        checkOutput("refill", 8'h17, 8'h16, 4'd8, 1'b0, 1'b1, 1'b0);
        applyStimulus(M_OVER, 8'h00);
        checkOutput("over_full", 8'h17, 8'h16, 4'd8, 1'b0, 1'b1, 1'b1);
        applyStimulus(M_DUP, 8'h00);
        checkOutput("dup_full", 8'h17, 8'h16, 4'd8, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(M_IDLE, 8'h5A);
            checkOutput($sformatf("idle%0d", i), 8'h17, 8'h16, 4'd8, 1'b0, 1'b1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
